// File: rtl/coef_serializer.sv
// -----------------------------------------------------------------------------
// coef_serializer
//
// Reader side of the softmax coefficient FIFO. Pops one packed word per
// subgraph (MAX_NODES coefficients of DATA_WIDTH bits, MSB first, followed by
// num_of_nodes in the low bits), checks the node count, and streams the valid
// coefficients one per beat over a valid/ready interface. Each beat carries its
// index within the subgraph, a last flag and the running subgraph index.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   coef_dout   in   FIFO read data, valid the cycle after coef_rd_en
//   coef_empty  in   FIFO empty
//   coef_rd_en  out  FIFO pop (only while coef_empty=0)
//   coef_valid  out  output beat valid
//   coef_ready  in   downstream accept
//   coef_data   out  current coefficient
//   coef_idx    out  0-based beat index within the subgraph
//   coef_last   out  final beat of the subgraph
//   sg_idx      out  index of the subgraph being streamed
//   all_done    out  one-cycle pulse after the last beat of subgraph NUM_SUBGRAPHS-1
//   len_err     out  one-cycle pulse when a word carries an invalid node count
//
// Optional feature macro: COEF_SERIALIZER_PREFETCH_EN
//   Adds a one-word holding register that is filled while streaming so the
//   next subgraph starts without a bubble.
// -----------------------------------------------------------------------------
module coef_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_NODES      = 6,
  parameter int NUM_NODE_WIDTH = $clog2(MAX_NODES),
  parameter int NUM_SUBGRAPHS  = 100,
  parameter int SOFTMAX_WIDTH  = MAX_NODES * DATA_WIDTH + NUM_NODE_WIDTH,
  parameter int SOFTMAX_ADDR_W = $clog2(NUM_SUBGRAPHS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SOFTMAX_WIDTH-1:0]  coef_dout,
  input  logic                      coef_empty,
  output logic                      coef_rd_en,
  output logic                      coef_valid,
  input  logic                      coef_ready,
  output logic [DATA_WIDTH-1:0]     coef_data,
  output logic [NUM_NODE_WIDTH-1:0] coef_idx,
  output logic                      coef_last,
  output logic [SOFTMAX_ADDR_W-1:0] sg_idx,
  output logic                      all_done,
  output logic                      len_err
);

  localparam int COEF_BITS = MAX_NODES * DATA_WIDTH;
  localparam logic [NUM_NODE_WIDTH:0]   MAX_N   = (NUM_NODE_WIDTH+1)'(MAX_NODES);
  localparam logic [SOFTMAX_ADDR_W-1:0] LAST_SG = SOFTMAX_ADDR_W'(NUM_SUBGRAPHS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [COEF_BITS-1:0]      r_shift;
  logic [NUM_NODE_WIDTH-1:0] r_n;
  logic [NUM_NODE_WIDTH-1:0] r_idx;
  logic [SOFTMAX_ADDR_W-1:0] r_sg;
  logic                      r_all_done;
  logic                      r_len_err;
  logic                      r_len_err_pend;

  logic                      w_rd_en;
  logic                      w_load;
  logic [SOFTMAX_WIDTH-1:0]  w_load_word;
  logic                      w_err_now;
  logic                      w_done_now;
  logic                      w_hs;
  logic                      w_last;
  logic                      w_last_hs;

  // A node count is usable when it lies in 1..MAX_NODES.
  function automatic logic f_len_ok(input logic [NUM_NODE_WIDTH-1:0] n);
    logic [NUM_NODE_WIDTH:0] n_ext;
    n_ext = {1'b0, n};
    return (n_ext != '0) && (n_ext <= MAX_N);
  endfunction

  assign w_hs       = (r_state == S_STREAM) && coef_ready;
  assign w_last     = (r_idx == r_n - 1'b1);
  assign w_last_hs  = w_hs && w_last;
  assign w_done_now = w_last_hs && (r_sg == LAST_SG);

`ifdef COEF_SERIALIZER_PREFETCH_EN
  logic [SOFTMAX_WIDTH-1:0] r_hold;
  logic                     r_hold_full;
  logic [1:0]               r_pf_pipe;   // [0]: pop issued last cycle, [1]: data on coef_dout now
  logic                     w_pf_rd;
  logic                     w_take_hold;
  logic                     w_hold_avail;
  logic [SOFTMAX_WIDTH-1:0] w_hold_word;

  // A prefetched word is usable either from the holding register or, in the
  // cycle it arrives, straight off the FIFO bus. This keeps short subgraphs
  // bubble-free even when the pop lands just before the last beat.
  assign w_hold_avail = r_hold_full || r_pf_pipe[1];
  assign w_hold_word  = r_hold_full ? r_hold : coef_dout;
`endif

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_load       = 1'b0;
    w_load_word  = coef_dout;
    w_err_now    = 1'b0;
`ifdef COEF_SERIALIZER_PREFETCH_EN
    w_pf_rd      = 1'b0;
    w_take_hold  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef COEF_SERIALIZER_PREFETCH_EN
        if (w_hold_avail) begin
          w_take_hold = 1'b1;
          w_load_word = w_hold_word;
          if (f_len_ok(w_hold_word[NUM_NODE_WIDTH-1:0])) begin
            w_load       = 1'b1;
            w_state_next = S_STREAM;
          end else begin
            w_err_now = 1'b1;
          end
        end else if (r_pf_pipe == 2'b00 && !coef_empty) begin
          // Wait for any in-flight prefetch before issuing a fresh pop.
          w_rd_en      = 1'b1;
          w_state_next = S_FETCH;
        end
`else
        if (!coef_empty) begin
          w_rd_en      = 1'b1;
          w_state_next = S_FETCH;
        end
`endif
      end
      S_FETCH: begin
        w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (f_len_ok(coef_dout[NUM_NODE_WIDTH-1:0])) begin
          w_load       = 1'b1;
          w_state_next = S_STREAM;
        end else begin
          w_err_now    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_STREAM: begin
`ifdef COEF_SERIALIZER_PREFETCH_EN
        if (!r_hold_full && r_pf_pipe == 2'b00 && !coef_empty) begin
          w_pf_rd = 1'b1;
          w_rd_en = 1'b1;
        end
        if (w_last_hs) begin
          if (w_hold_avail) begin
            w_take_hold = 1'b1;
            w_load_word = w_hold_word;
            if (f_len_ok(w_hold_word[NUM_NODE_WIDTH-1:0])) begin
              w_load       = 1'b1;
              w_state_next = S_STREAM;
            end else begin
              w_err_now    = 1'b1;
              w_state_next = S_IDLE;
            end
          end else begin
            w_state_next = S_IDLE;
          end
        end
`else
        if (w_last_hs) begin
          w_state_next = S_IDLE;
        end
`endif
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_n            <= '0;
      r_idx          <= '0;
      r_sg           <= '0;
      r_all_done     <= 1'b0;
      r_len_err      <= 1'b0;
      r_len_err_pend <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_load) begin
        r_shift <= w_load_word[SOFTMAX_WIDTH-1 -: COEF_BITS];
        r_n     <= w_load_word[NUM_NODE_WIDTH-1:0];
        r_idx   <= '0;
      end else if (w_hs) begin
        r_shift <= {r_shift[COEF_BITS-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
      end

      if (w_last_hs) begin
        r_sg <= (r_sg == LAST_SG) ? '0 : r_sg + 1'b1;
      end

      // An invalid prefetched word can surface on the very handshake that
      // wraps sg_idx; its len_err is pushed one cycle later so the two
      // pulses never overlap.
      r_all_done     <= w_done_now;
      r_len_err      <= r_len_err_pend || (w_err_now && !w_done_now);
      r_len_err_pend <= w_err_now && w_done_now;
    end
  end

`ifdef COEF_SERIALIZER_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_pf_pipe   <= 2'b00;
    end else begin
      r_pf_pipe <= {r_pf_pipe[0], w_pf_rd};
      if (w_take_hold) begin
        r_hold_full <= 1'b0;
      end else if (r_pf_pipe[1]) begin
        r_hold      <= coef_dout;
        r_hold_full <= 1'b1;
      end
    end
  end
`endif

  // The pop strobe is combinational from IDLE/STREAM; gate it so it is
  // quiet while reset is held.
  assign coef_rd_en = w_rd_en && !rst;
  assign coef_valid = (r_state == S_STREAM);
  assign coef_data  = r_shift[COEF_BITS-1 -: DATA_WIDTH];
  assign coef_idx   = r_idx;
  assign coef_last  = (r_state == S_STREAM) && w_last;
  assign sg_idx     = r_sg;
  assign all_done   = r_all_done;
  assign len_err    = r_len_err;

endmodule

// File: tb/tb_coef_serializer.sv
// -----------------------------------------------------------------------------
// tb_coef_serializer
//
// Bench for coef_serializer. A FIFO model feeds packed words; every popped word
// is expanded into its expected beats (data, idx, last, sg) by a simple
// queue-based reference, and a per-cycle compare routine checks the DUT
// outputs against it. Directed scenarios add hand-computed expectations,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_coef_serializer;

  localparam int DW  = 8;
  localparam int NN  = 6;
  localparam int NW  = 3;
  localparam int NSG = 100;
  localparam int SW  = 51;
  localparam int AW  = 7;
`ifdef COEF_SERIALIZER_PREFETCH_EN
  localparam int BOUNDARY_SPAN = 5;   // 3+3 beats back to back
`else
  localparam int BOUNDARY_SPAN = 8;   // 3 idle cycles between subgraphs
`endif

  logic          clk;
  logic          rst;
  logic [SW-1:0] coef_dout;
  logic          coef_empty;
  logic          coef_rd_en;
  logic          coef_valid;
  logic          coef_ready;
  logic [DW-1:0] coef_data;
  logic [NW-1:0] coef_idx;
  logic          coef_last;
  logic [AW-1:0] sg_idx;
  logic          all_done;
  logic          len_err;

  coef_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .coef_dout  (coef_dout),
    .coef_empty (coef_empty),
    .coef_rd_en (coef_rd_en),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_idx   (coef_idx),
    .coef_last  (coef_last),
    .sg_idx     (sg_idx),
    .all_done   (all_done),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NW-1:0] idx;
    logic          last;
    logic [AW-1:0] sg;
  } beat_t;

  logic [SW-1:0] fq[$];       // FIFO contents
  beat_t         exp_q[$];    // expected beats, in order
  int            m_sg;
  int            exp_len_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // compare state
  logic          exp_done_next;
  logic          prev_stall;
  logic [DW-1:0] p_data;
  logic [NW-1:0] p_idx;
  logic          p_last;
  int            n_len;
  int            n_done;

  // per-test log
  int hs_data[$];
  int hs_idx[$];
  int hs_sg[$];
  int hs_cyc[$];
  int fv_cyc;
  int rd_cyc;
  int base_len;
  int base_done;
  int base_exp_len;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [SW-1:0] mk_word(input logic [47:0] c, input logic [2:0] n);
    return {c, n};
  endfunction

  // Reference: a popped word becomes n beats, coef_1 first, or one len_err.
  task automatic model_push(input logic [SW-1:0] w);
    int    n;
    beat_t b;
    n = int'(w[2:0]);
    if (n < 1 || n > NN) begin
      exp_len_err++;
    end else begin
      for (int i = 0; i < n; i++) begin
        b.d    = w[SW-1-DW*i -: DW];
        b.idx  = NW'(i);
        b.last = (i == n - 1);
        b.sg   = AW'(m_sg);
        exp_q.push_back(b);
      end
      m_sg = (m_sg + 1) % NSG;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sg          = 0;
    exp_done_next = 1'b0;
    prev_stall    = 1'b0;
  endtask

  task automatic clear_log();
    hs_data.delete();
    hs_idx.delete();
    hs_sg.delete();
    hs_cyc.delete();
    fv_cyc       = -1;
    rd_cyc       = -1;
    base_len     = n_len;
    base_done    = n_done;
    base_exp_len = exp_len_err;
  endtask

  // Per-cycle comparison of the DUT outputs against the reference; sees the
  // values that the coming rising edge will act on.
  task automatic check();
    beat_t b;
    if (rst) return;
    chk(all_done == exp_done_next, "all_done", int'(all_done), int'(exp_done_next));
    chk(!(all_done && len_err), "pulse_overlap", int'(len_err), 0);
    if (all_done) n_done++;
    if (len_err)  n_len++;
    if (prev_stall) begin
      chk(coef_valid && coef_data == p_data && coef_idx == p_idx && coef_last == p_last,
          "stall_hold", int'(coef_data), int'(p_data));
    end
    exp_done_next = 1'b0;
    if (coef_valid) begin
      if (fv_cyc < 0) fv_cyc = cyc;
      chk(exp_q.size() > 0, "spurious_valid", int'(coef_data), -1);
      if (exp_q.size() > 0) begin
        b = exp_q[0];
        chk(coef_data == b.d,    "data", int'(coef_data), int'(b.d));
        chk(coef_idx  == b.idx,  "idx",  int'(coef_idx),  int'(b.idx));
        chk(coef_last == b.last, "last", int'(coef_last), int'(b.last));
        chk(sg_idx    == b.sg,   "sg",   int'(sg_idx),    int'(b.sg));
        if (coef_ready) begin
          void'(exp_q.pop_front());
          hs_data.push_back(int'(coef_data));
          hs_idx.push_back(int'(coef_idx));
          hs_sg.push_back(int'(sg_idx));
          hs_cyc.push_back(cyc);
          if (b.last && int'(b.sg) == NSG - 1) exp_done_next = 1'b1;
        end
      end
    end
    prev_stall = coef_valid && !coef_ready;
    p_data     = coef_data;
    p_idx      = coef_idx;
    p_last     = coef_last;
  endtask

  // One clock cycle: check, sample pop, model FIFO read latency.
  task automatic step();
    logic          rd;
    logic [SW-1:0] w;
    #1;
    check();
    rd = coef_rd_en;
    if (rd) begin
      chk(fq.size() > 0, "rd_en_when_empty", int'(rd), 0);
      if (rd_cyc < 0) rd_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (rd && !rst && fq.size() > 0) begin
      w = fq.pop_front();
      coef_dout = w;
      model_push(w);
    end
    coef_empty = (fq.size() == 0);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic [SW-1:0] w);
    fq.push_back(w);
    coef_empty = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(coef_rd_en == 1'b0 && coef_valid == 1'b0 && coef_last == 1'b0 &&
        all_done == 1'b0 && len_err == 1'b0, {tag, "_ctrl"},
        int'({coef_rd_en, coef_valid, coef_last, all_done, len_err}), 0);
    chk(coef_data == '0 && coef_idx == '0 && sg_idx == '0, {tag, "_data"},
        int'(coef_data) + int'(coef_idx) + int'(sg_idx), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset");
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    coef_ready = 1'b1;
    repeat (n) step();
  endtask

  // mode 0: ready always 1; mode 1: pattern 1,0,0,1
  task automatic run_until(input int nbeats, input int bound, input int mode, input string name);
    int k;
    for (k = 0; k < bound; k++) begin
      if (hs_data.size() >= nbeats) break;
      if (mode == 1) coef_ready = (k % 4 == 0) || (k % 4 == 3);
      else           coef_ready = 1'b1;
      step();
    end
    chk(hs_data.size() >= nbeats, {name, "_timeout"}, hs_data.size(), nbeats);
  endtask

  initial begin
    logic [SW-1:0] w;
    int            pushed;
    int            n;

    rst        = 1'b1;
    coef_dout  = '0;
    coef_empty = 1'b1;
    coef_ready = 1'b0;
    n_len      = 0;
    n_done     = 0;
    exp_len_err = 0;
    model_reset();
    clear_log();
    @(negedge clk);
    do_reset();

    // ---- full n=6 word, ready high --------------------------------------
    clear_log();
    push(mk_word(48'h112233445566, 3'd6));
    run_until(6, 40, 0, "t1");
    idle(4);
    if (hs_data.size() >= 6) begin
      chk(hs_data[0] == 'h11, "t1_first_data", hs_data[0], 'h11);
      chk(hs_data[5] == 'h66, "t1_last_data", hs_data[5], 'h66);
      chk(hs_idx[5] == 5, "t1_last_idx", hs_idx[5], 5);
      chk(hs_cyc[5] - hs_cyc[0] == 5, "t1_back_to_back", hs_cyc[5] - hs_cyc[0], 5);
    end
    chk(fv_cyc - rd_cyc == 3, "t1_latency", fv_cyc - rd_cyc, 3);
    chk(sg_idx == 7'd1, "t1_sg_after", int'(sg_idx), 1);

    // ---- n=2 word with stalls --------------------------------------------
    do_reset();
    clear_log();
    push(mk_word(48'hA0B0C0D0E0F0, 3'd2));
    run_until(2, 40, 1, "t2");
    idle(6);
    chk(hs_data.size() == 2, "t2_beats", hs_data.size(), 2);
    if (hs_data.size() >= 2) begin
      chk(hs_data[0] == 'hA0, "t2_beat0", hs_data[0], 'hA0);
      chk(hs_data[1] == 'hB0, "t2_beat1", hs_data[1], 'hB0);
      chk(hs_sg[0] == 0, "t2_sg_during", hs_sg[0], 0);
    end
    chk(sg_idx == 7'd1, "t2_sg_after", int'(sg_idx), 1);

    // ---- invalid counts then a valid word -------------------------------
    do_reset();
    clear_log();
    push(mk_word(48'h010203040506, 3'd0));
    push(mk_word(48'h010203040506, 3'd7));
    push(mk_word(48'h5A0000000000, 3'd1));
    run_until(1, 60, 0, "t3");
    idle(6);
    chk(n_len - base_len == 2, "t3_len_err_pulses", n_len - base_len, 2);
    chk(hs_data.size() == 1, "t3_beats", hs_data.size(), 1);
    if (hs_data.size() >= 1) begin
      chk(hs_data[0] == 'h5A, "t3_data", hs_data[0], 'h5A);
      chk(hs_sg[0] == 0, "t3_sg_unchanged", hs_sg[0], 0);
    end

    // ---- async reset during the third beat -------------------------------
    do_reset();
    clear_log();
    push(mk_word(48'h616263646566, 3'd6));
    run_until(2, 40, 0, "t5");
    chk(coef_valid && coef_idx == 3'd2, "t5_third_beat", int'(coef_idx), 2);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t5_async");
    model_reset();
    @(negedge clk);
    cyc++;
    step();
    rst = 1'b0;
    step();
    clear_log();
    push(mk_word(48'hC1C2C3C40000, 3'd4));
    run_until(4, 40, 0, "t5b");
    idle(4);
    if (hs_data.size() >= 1) begin
      chk(hs_idx[0] == 0, "t5_restart_idx", hs_idx[0], 0);
      chk(hs_data[0] == 'hC1, "t5_restart_data", hs_data[0], 'hC1);
      chk(hs_sg[0] == 0, "t5_restart_sg", hs_sg[0], 0);
    end

    // ---- 100 single-node subgraphs: wrap and all_done -------------------
    do_reset();
    clear_log();
    for (int i = 0; i < NSG; i++) begin
      w = mk_word({8'(i), 40'h0}, 3'd1);
      push(w);
    end
    run_until(NSG, 2000, 0, "t4");
    idle(6);
    chk(n_done - base_done == 1, "t4_all_done_pulses", n_done - base_done, 1);
    chk(sg_idx == 7'd0, "t4_sg_wrapped", int'(sg_idx), 0);
    if (hs_sg.size() >= NSG) begin
      chk(hs_sg[NSG-1] == NSG - 1, "t4_last_sg", hs_sg[NSG-1], NSG - 1);
      chk(hs_data[NSG-1] == NSG - 1, "t4_last_data", hs_data[NSG-1], NSG - 1);
    end

    // ---- two n=3 words queued: subgraph boundary spacing ----------------
    do_reset();
    clear_log();
    push(mk_word(48'h010203000000, 3'd3));
    push(mk_word(48'h040506000000, 3'd3));
    run_until(6, 60, 0, "t6");
    idle(4);
    if (hs_cyc.size() >= 6) begin
      chk(hs_cyc[5] - hs_cyc[0] == BOUNDARY_SPAN, "t6_boundary_span",
          hs_cyc[5] - hs_cyc[0], BOUNDARY_SPAN);
      chk(hs_data[3] == 'h04, "t6_second_first", hs_data[3], 'h04);
    end

    // ---- randomized run -------------------------------------------------
    do_reset();
    clear_log();
    pushed = 0;
    for (int k = 0; k < 8000; k++) begin
      if (pushed >= 250 && fq.size() == 0 && exp_q.size() == 0 && !coef_valid) break;
      if (pushed < 250 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 8) n = int'($urandom_range(1, 6));
        else                          n = ($urandom_range(0, 1) == 0) ? 0 : 7;
        w = mk_word({$urandom(), 16'($urandom())}, 3'(n));
        push(w);
        pushed++;
      end
      coef_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle(10);
    chk(exp_q.size() == 0, "rand_drained", exp_q.size(), 0);
    chk(fq.size() == 0, "rand_fifo_empty", fq.size(), 0);
    chk(n_len - base_len == exp_len_err - base_exp_len, "rand_len_err_count",
        n_len - base_len, exp_len_err - base_exp_len);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_serializer.md
# coef_serializer

Reader side of the softmax coefficient FIFO. Pops one packed `coef_t` word per subgraph (six DATA_WIDTH coefficients plus `num_of_nodes`), validates the node count, and streams the valid coefficients one per beat over a valid/ready interface to the softmax datapath. It tags each beat with its index, a last flag and the running subgraph index. It also flags completion of all NUM_SUBGRAPHS subgraphs.

## Interface
- DATA_WIDTH, 8, coefficient width
- MAX_NODES, 6, coefficients per packed word
- NUM_NODE_WIDTH, $clog2(MAX_NODES) = 3, width of `num_of_nodes`
- NUM_SUBGRAPHS, 100, subgraphs per inference run
- SOFTMAX_WIDTH, MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH = 51, FIFO word width
- SOFTMAX_ADDR_W, $clog2(NUM_SUBGRAPHS) = 7, subgraph index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- coef_dout  in  SOFTMAX_WIDTH  FIFO read data, valid the cycle after `coef_rd_en`
- coef_empty  in  1  FIFO empty
- coef_rd_en  out  1  FIFO pop, only asserted when `coef_empty`=0
- coef_valid  out  1  output beat valid
- coef_ready  in  1  downstream accept
- coef_data  out  DATA_WIDTH  current coefficient
- coef_idx  out  NUM_NODE_WIDTH  0-based index within subgraph
- coef_last  out  1  final beat of subgraph
- sg_idx  out  SOFTMAX_ADDR_W  index of subgraph being streamed
- all_done  out  1  one-cycle pulse after last beat of subgraph NUM_SUBGRAPHS-1
- len_err  out  1  one-cycle pulse on invalid `num_of_nodes`

## Operation
- Word layout, MSB first: coef_1 [50:43], coef_2 … coef_6 [10:3], num_of_nodes [2:0]. Beats are emitted coef_1 first.
- FSM states: IDLE, FETCH, LOAD, STREAM.
  - IDLE: if `coef_empty`=0, assert `coef_rd_en` and go to FETCH.
  - FETCH: wait one cycle for read latency, then go to LOAD.
  - LOAD: capture `coef_dout` into the shift register and capture `n = num_of_nodes`.
    - If 1 ≤ n ≤ MAX_NODES: go to STREAM.
    - Otherwise: pulse `len_err`, drop the word, go to IDLE. `sg_idx` is not advanced.
  - STREAM: `coef_valid`=1. On `coef_valid && coef_ready`: shift left by DATA_WIDTH and increment `coef_idx`.
    - `coef_last` = (`coef_idx` == n-1).
    - A handshake on the last beat returns to IDLE, resets `coef_idx` to 0 and advances `sg_idx`.
- `sg_idx` wraps from NUM_SUBGRAPHS-1 to 0. `all_done` pulses in the cycle after that wrapping handshake.
- `coef_data`, `coef_idx`, `coef_last` hold stable while `coef_valid && !coef_ready`.
- Reset mid-operation: all state clears immediately; a word already popped is discarded.

## Timing
- Reset values: `coef_rd_en`=0, `coef_valid`=0, `coef_data`=0, `coef_idx`=0, `coef_last`=0, `sg_idx`=0, `all_done`=0, `len_err`=0. FSM resets to IDLE.
- Latency: `coef_rd_en` at cycle T, then LOAD at T+2, then first `coef_valid` at T+3.
- Throughput within a subgraph: 1 beat/cycle while `coef_ready`=1.
- Without prefetch, there are 3 idle cycles between the last beat of one subgraph and the first beat of the next.
- `coef_empty` is sampled only in IDLE, or in STREAM when prefetch is enabled. A FIFO that goes empty mid-stream has no effect on the current subgraph.
- `len_err` and `all_done` are registered, single-cycle, and never asserted together.

## Configuration
- `COEF_SERIALIZER_PREFETCH_EN` defined: adds one holding register plus a full bit.
  - In STREAM, if the holding register is empty and `coef_empty`=0, assert `coef_rd_en`; capture `coef_dout` into the holding register 2 cycles later.
  - On the last-beat handshake with the holding register full, load it straight into the shift register. Validity is checked the same way; an invalid word pulses `len_err`.
  - The next subgraph's first beat follows in the next cycle, with zero bubble.
  - IDLE/FETCH/LOAD are still used when the holding register is empty.
- Not defined: behaviour exactly as in Operation. No holding register; `coef_rd_en` is asserted only from IDLE.

## Test plan
- Word {0x11,0x22,0x33,0x44,0x55,0x66,n=6}, `coef_ready`=1 -> beats 0x11..0x66 on 6 consecutive cycles, idx 0..5, `coef_last` only on 0x66, first valid 3 cycles after `coef_rd_en`.
- n=2 word {0xA0,0xB0,…}, `coef_ready` toggling 1,0,0,1 -> exactly 2 beats 0xA0, 0xB0; data held stable during stalls; `sg_idx` goes 0→1.
- n=0, then n=7 words -> two `len_err` pulses, no `coef_valid`, `sg_idx` unchanged, and the next valid word is streamed normally.
- 100 words with n=1 -> `all_done` pulses once after the 100th beat and `sg_idx` returns to 0.
- Assert `rst` during the 3rd beat of an n=6 word -> all outputs go to 0 asynchronously; after release, the next FIFO word streams from idx 0.
- With `COEF_SERIALIZER_PREFETCH_EN`, two n=3 words pre-queued -> 6 beats on 6 consecutive cycles with no bubble at the subgraph boundary.
